// File: rtl/tl_ul_buffer.sv
// TileLink-UL A/D channel buffer with in-flight request throttling.
// Optional feature macro TL_UL_BUFFER_FLOW_EN: 0-cycle flow-through on empty FIFOs.

module tl_ul_buffer_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    input  logic         in_ready,
    input  logic [W-1:0] in_bits,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_bits,
    output logic         full,
    output logic         empty
);
    localparam int P_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int C_W = $clog2(DEPTH + 1);
    localparam logic [P_W-1:0] LAST = P_W'(DEPTH - 1);

    logic [W-1:0]   mem [DEPTH];
    logic [P_W-1:0] wr_ptr;
    logic [P_W-1:0] rd_ptr;
    logic [C_W-1:0] count;
    logic           push;
    logic           pop;

    assign full  = (count == C_W'(DEPTH));
    assign empty = (count == '0);

`ifdef TL_UL_BUFFER_FLOW_EN
    logic bypass;
    // An accepted beat that leaves in the same cycle is never written.
    assign bypass    = empty && in_valid && in_ready && out_ready;
    assign out_valid = empty ? (in_valid && in_ready) : 1'b1;
    assign out_bits  = empty ? in_bits : mem[rd_ptr];
    assign push      = in_valid && in_ready && !bypass;
    assign pop       = !empty && out_ready;
`else
    assign out_valid = !empty;
    assign out_bits  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_bits;
                wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

module tl_ul_buffer #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int SRC_W        = 1,
    parameter int A_DEPTH      = 2,
    parameter int D_DEPTH      = 2,
    parameter int MAX_INFLIGHT = 4,
    localparam int A_W  = 3 + 3 + 4 + SRC_W + ADDR_W + DATA_W / 8 + DATA_W + 1,
    localparam int D_W  = 3 + 2 + 4 + SRC_W + 1 + 1 + DATA_W + 1,
    localparam int IF_W = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            a_in_valid,
    output logic            a_in_ready,
    input  logic [A_W-1:0]  a_in_bits,
    output logic            a_out_valid,
    input  logic            a_out_ready,
    output logic [A_W-1:0]  a_out_bits,
    input  logic            d_in_valid,
    output logic            d_in_ready,
    input  logic [D_W-1:0]  d_in_bits,
    output logic            d_out_valid,
    input  logic            d_out_ready,
    output logic [D_W-1:0]  d_out_bits,
    output logic [IF_W-1:0] inflight,
    output logic            idle
);
    logic a_full;
    logic a_empty;
    logic d_full;
    logic d_empty;
    logic a_fire;
    logic d_fire;
    logic at_limit;

    // Readies depend on registered counts only, never on out_ready.
    assign at_limit   = (inflight == IF_W'(MAX_INFLIGHT));
    assign a_in_ready = !a_full && !at_limit;
    assign d_in_ready = !d_full;
    assign a_fire     = a_in_valid && a_in_ready;
    assign d_fire     = d_out_valid && d_out_ready;
    assign idle       = a_empty && d_empty && (inflight == '0);

    tl_ul_buffer_fifo #(
        .W     (A_W),
        .DEPTH (A_DEPTH)
    ) u_a_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_bits   (a_in_bits),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_bits  (a_out_bits),
        .full      (a_full),
        .empty     (a_empty)
    );

    tl_ul_buffer_fifo #(
        .W     (D_W),
        .DEPTH (D_DEPTH)
    ) u_d_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (d_in_valid),
        .in_ready  (d_in_ready),
        .in_bits   (d_in_bits),
        .out_valid (d_out_valid),
        .out_ready (d_out_ready),
        .out_bits  (d_out_bits),
        .full      (d_full),
        .empty     (d_empty)
    );

    // A response with nothing outstanding is a protocol error; hold at zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= '0;
        end else if (a_fire && !d_fire) begin
            inflight <= inflight + 1'b1;
        end else if (d_fire && !a_fire && (inflight != '0)) begin
            inflight <= inflight - 1'b1;
        end
    end
endmodule

// File: tb/tb_tl_ul_buffer.sv
// Randomised, model-checked bench for tl_ul_buffer.
// Non-power-of-two FIFO depths exercise explicit pointer wrap.

module tb_tl_ul_buffer;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SRC_W  = 2;
    localparam int A_DEP  = 3;
    localparam int D_DEP  = 3;
    localparam int MAXI   = 4;
    localparam int A_W    = 3 + 3 + 4 + SRC_W + ADDR_W + DATA_W / 8 + DATA_W + 1;
    localparam int D_W    = 3 + 2 + 4 + SRC_W + 1 + 1 + DATA_W + 1;
    localparam int IF_W   = $clog2(MAXI + 1);
    localparam int ADDR_LSB = DATA_W + DATA_W / 8 + 1;

    logic            clock = 1'b0;
    logic            reset_n = 1'b1;
    logic            a_in_valid = 1'b0;
    logic            a_in_ready;
    logic [A_W-1:0]  a_in_bits = '0;
    logic            a_out_valid;
    logic            a_out_ready = 1'b0;
    logic [A_W-1:0]  a_out_bits;
    logic            d_in_valid = 1'b0;
    logic            d_in_ready;
    logic [D_W-1:0]  d_in_bits = '0;
    logic            d_out_valid;
    logic            d_out_ready = 1'b0;
    logic [D_W-1:0]  d_out_bits;
    logic [IF_W-1:0] inflight;
    logic            idle;

    tl_ul_buffer #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .SRC_W        (SRC_W),
        .A_DEPTH      (A_DEP),
        .D_DEPTH      (D_DEP),
        .MAX_INFLIGHT (MAXI)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .a_in_valid  (a_in_valid),
        .a_in_ready  (a_in_ready),
        .a_in_bits   (a_in_bits),
        .a_out_valid (a_out_valid),
        .a_out_ready (a_out_ready),
        .a_out_bits  (a_out_bits),
        .d_in_valid  (d_in_valid),
        .d_in_ready  (d_in_ready),
        .d_in_bits   (d_in_bits),
        .d_out_valid (d_out_valid),
        .d_out_ready (d_out_ready),
        .d_out_bits  (d_out_bits),
        .inflight    (inflight),
        .idle        (idle)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: channel contents as queues plus an outstanding count.
    logic [A_W-1:0] aq[$];
    logic [D_W-1:0] dq[$];
    int  minf;
    int  spend;
    int  d_made;
    int  d_seen;
    int  a_acc;
    int  a_outs;
    bit  chk_en = 1'b0;
    bit  seq_mode = 1'b0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("a_in_ready", 128'(a_in_ready),
                128'(aq.size() != A_DEP && minf != MAXI));
            chk("d_in_ready", 128'(d_in_ready), 128'(dq.size() != D_DEP));
            chk("a_out_valid", 128'(a_out_valid), 128'(aq.size() != 0));
            chk("d_out_valid", 128'(d_out_valid), 128'(dq.size() != 0));
            chk("inflight", 128'(inflight), 128'(minf));
            chk("idle", 128'(idle),
                128'(aq.size() == 0 && dq.size() == 0 && minf == 0));
            if (aq.size() != 0) chk("a_out_bits", 128'(a_out_bits), 128'(aq[0]));
            if (dq.size() != 0) chk("d_out_bits", 128'(d_out_bits), 128'(dq[0]));
        end
    end

    task automatic do_reset(input string name);
        a_in_valid  = 1'b0;
        d_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        d_out_ready = 1'b0;
        chk_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        chk({name, "_a_out_valid"}, 128'(a_out_valid), 128'(0));
        chk({name, "_d_out_valid"}, 128'(d_out_valid), 128'(0));
        chk({name, "_a_in_ready"}, 128'(a_in_ready), 128'(1));
        chk({name, "_d_in_ready"}, 128'(d_in_ready), 128'(1));
        chk({name, "_inflight"}, 128'(inflight), 128'(0));
        chk({name, "_idle"}, 128'(idle), 128'(1));
        chk({name, "_a_out_bits"}, 128'(a_out_bits), 128'(0));
        chk({name, "_d_out_bits"}, 128'(d_out_bits), 128'(0));
        aq.delete();
        dq.delete();
        minf = 0; spend = 0; d_made = 0; d_seen = 0; a_acc = 0; a_outs = 0;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk_en = 1'b1;
    endtask

    // Entered and left just after a falling edge; pX are percent probabilities.
    task automatic run_cycle(input int pa, input int po, input int pd, input int pr);
        bit af_in, af_out, df_in, df_out;
        a_in_valid = ($urandom_range(99) < pa);
        if (seq_mode)
            a_in_bits = {3'd4, 3'd0, 4'd2, SRC_W'(0),
                         ADDR_W'(32'h1000 + 4 * a_acc), 4'hF, 32'd0, 1'b0};
        else
            a_in_bits = A_W'({$urandom, $urandom, $urandom});
        a_out_ready = ($urandom_range(99) < po);
        d_in_valid  = (spend > 0) && ($urandom_range(99) < pd);
        d_in_bits   = {3'd1, 2'd0, 4'd2, SRC_W'($urandom), 1'b0, 1'b0,
                       DATA_W'(32'hA5A5_0000 + d_made), 1'b0};
        d_out_ready = ($urandom_range(99) < pr);
        af_in  = a_in_valid && aq.size() != A_DEP && minf != MAXI;
        af_out = (aq.size() != 0) && a_out_ready;
        df_in  = d_in_valid && dq.size() != D_DEP;
        df_out = (dq.size() != 0) && d_out_ready;
        if (af_out && seq_mode)
            chk("a_out_addr", 128'(a_out_bits[ADDR_LSB +: ADDR_W]),
                128'(32'h1000 + 4 * a_outs));
        if (df_out)
            chk("d_out_order", 128'(d_out_bits[1 +: DATA_W]),
                128'(32'hA5A5_0000 + d_seen));
        @(posedge clock);
        if (af_out) begin void'(aq.pop_front()); spend++; a_outs++; end
        if (af_in) begin aq.push_back(a_in_bits); a_acc++; end
        if (df_in) begin dq.push_back(d_in_bits); spend--; d_made++; end
        if (df_out) begin void'(dq.pop_front()); d_seen++; end
        if (af_in && !df_out) minf++;
        else if (df_out && !af_in && minf > 0) minf--;
        @(negedge clock);
        #1;
    endtask

    initial begin
        int base;
        #2;
        do_reset("por");

        seq_mode = 1'b1;
        run_cycle(100, 100, 100, 100);
        chk("stream_first_valid", 128'(a_out_valid), 128'(1));
        for (int i = 1; i < 8; i++) run_cycle(100, 100, 100, 100);
        chk("stream_accepted", 128'(a_acc), 128'(8));
        for (int i = 0; i < 6; i++) run_cycle(0, 100, 100, 100);
        chk("stream_out", 128'(a_outs), 128'(8));
        chk("stream_idle", 128'(idle), 128'(1));
        seq_mode = 1'b0;

        base = a_acc;
        for (int i = 0; i < 5; i++) run_cycle(100, 0, 0, 0);
        chk("bp_accepted", 128'(a_acc - base), 128'(3));
        chk("bp_ready_low", 128'(a_in_ready), 128'(0));
        run_cycle(0, 100, 0, 0);
        chk("bp_ready_back", 128'(a_in_ready), 128'(1));
        for (int i = 0; i < 10; i++) run_cycle(0, 100, 100, 100);

        for (int i = 0; i < 6; i++) run_cycle(100, 100, 0, 0);
        chk("lim_inflight", 128'(inflight), 128'(4));
        chk("lim_ready_low", 128'(a_in_ready), 128'(0));
        run_cycle(0, 0, 100, 0);
        run_cycle(0, 0, 0, 100);
        chk("lim_inflight_dec", 128'(inflight), 128'(3));
        chk("lim_ready_back", 128'(a_in_ready), 128'(1));
        for (int i = 0; i < 10; i++) run_cycle(0, 100, 100, 100);

        do_reset("pre_sim");
        run_cycle(100, 100, 0, 0);
        run_cycle(100, 100, 0, 0);
        run_cycle(0, 100, 0, 0);
        run_cycle(0, 0, 100, 0);
        run_cycle(0, 0, 100, 0);
        chk("sim_before", 128'(inflight), 128'(2));
        run_cycle(100, 0, 0, 100);
        chk("sim_after", 128'(inflight), 128'(2));

        run_cycle(100, 0, 0, 0);
        chk("mid_a_stored", 128'(a_out_valid), 128'(1));
        do_reset("mid");

        for (int ph = 0; ph < 8; ph++) begin
            int pa, po, pd, pr;
            pa = $urandom_range(10, 100);
            po = $urandom_range(10, 100);
            pd = $urandom_range(10, 100);
            pr = $urandom_range(10, 100);
            for (int i = 0; i < 400; i++) run_cycle(pa, po, pd, pr);
        end
        for (int i = 0; i < 30; i++) run_cycle(0, 100, 100, 100);
        chk("final_idle", 128'(idle), 128'(1));

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tl_ul_buffer.md
# tl_ul_buffer

Parametrised TileLink-UL buffer inserted between a master port and a slave port on the core's memory/peripheral fabric. It buffers the A (request) and D (response) channels in independent circular FIFOs of configurable depth. It counts outstanding requests and throttles A when a configured in-flight limit is reached. It replaces fixed-width, zero-storage channel pass-through wiring, breaking both valid and ready timing paths.

## Interface

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; multiple of 8
- SRC_W, 1, source ID width
- A_DEPTH, 2, A FIFO entries; ≥1, need not be a power of two
- D_DEPTH, 2, D FIFO entries; ≥1, need not be a power of two
- MAX_INFLIGHT, 4, maximum accepted-but-unanswered requests; ≥1

Derived widths:
- A_W = 3+3+4+SRC_W+ADDR_W+DATA_W/8+DATA_W+1
- D_W = 3+2+4+SRC_W+1+1+DATA_W+1

Ports (clock and reset first):
- clock  in  1  sole clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- a_in_valid  in  1  master A valid
- a_in_ready  out  1  A accept
- a_in_bits  in  A_W  {opcode, param, size, source, address, mask, data, corrupt}, MSB first
- a_out_valid  out  1  slave A valid
- a_out_ready  in  1  slave A ready
- a_out_bits  out  A_W  same packing as a_in_bits
- d_in_valid  in  1  slave D valid
- d_in_ready  out  1  D accept
- d_in_bits  in  D_W  {opcode, param[1:0], size, source, sink, denied, data, corrupt}, MSB first
- d_out_valid  out  1  master D valid
- d_out_ready  in  1  master D ready
- d_out_bits  out  D_W  same packing as d_in_bits
- inflight  out  clog2(MAX_INFLIGHT+1)  outstanding request count
- idle  out  1  both FIFOs empty and inflight==0

## Operation

- Each channel is a circular FIFO with read pointer, write pointer and count.
- Pointers wrap from DEPTH-1 to 0 explicitly; no modulo-2^n assumption.
- Enqueue on in_valid&&in_ready; dequeue on out_valid&&out_ready.
- Payload is stored unmodified; no field is decoded or altered.
- d_in_ready = (d_count != D_DEPTH).
- a_in_ready = (a_count != A_DEPTH) && (inflight != MAX_INFLIGHT).
- Both readies are functions of registered state only; there is no combinational path from out_ready to in_ready.
- inflight increments on A input fire and decrements on D output fire.
  - Both fire in one cycle: count unchanged.
  - Never exceeds MAX_INFLIGHT; never decremented below 0. A D output fire at 0 is a protocol error; the count saturates at 0.
- Full FIFO with an out fire in the same cycle: in_ready is already low, so there is no enqueue that cycle. in_ready rises the following cycle.
- Empty FIFO: out_valid=0, and out_bits holds the entry at the read pointer (stale data).
- The block never reorders within a channel and never drops a beat.

## Timing

- Reset (asynchronous assert, synchronous-safe deassert by the upstream synchroniser) clears:
  - pointers, counts and inflight to 0
  - all storage to 0, so out_bits=0
  - a_out_valid=0, d_out_valid=0
  - a_in_ready=1, d_in_ready=1, idle=1
- Reset mid-transfer discards all buffered beats and the in-flight count; there is no recovery handshake.
- Latency, macro absent: in fire in cycle N gives out_valid in cycle N+1 at the earliest.
- Throughput: one beat per cycle per channel when DEPTH≥2; DEPTH=1 gives one beat per two cycles.
- inflight updates one cycle after the fire. a_in_ready reflects the limit from the next cycle onward.

## Configuration

- Macro: TL_UL_BUFFER_FLOW_EN.
- Defined:
  - When a FIFO is empty, out_valid=in_valid and out_bits=in_bits combinationally, giving 0-cycle latency.
  - If out_ready is also high, the beat passes through without being written and the count is unchanged.
  - in_ready stays registered as specified above.
- Undefined: outputs come only from storage (1-cycle minimum latency), and no combinational valid/data path crosses the block.

## Test plan

- Reset: assert reset_n=0 mid-burst with 2 A entries stored -> all valids 0, readies 1, inflight=0, idle=1, out_bits=0, with no clock edge required.
- Back-to-back streaming: A_DEPTH=2, 8 consecutive Get beats with addresses 0x1000..0x101C, a_out_ready=1, D responses returned immediately -> 8 beats out in order, 1 beat/cycle, first a_out_valid at cycle+1 (macro off) or cycle+0 (macro on).
- Full/backpressure: A_DEPTH=3, a_out_ready=0, 5 beats offered -> exactly 3 accepted, a_in_ready=0. Raise a_out_ready -> a_in_ready returns 1 one cycle after the first dequeue.
- In-flight limit: MAX_INFLIGHT=4, D held off -> 4 requests accepted, a_in_ready=0, inflight=4. One D beat delivered -> inflight=3, a_in_ready=1 the next cycle.
- Simultaneous: A fire and D output fire in the same cycle at inflight=2 -> inflight stays 2. Non-power-of-two D_DEPTH=3 with 10 beats -> correct wrap and order with data 0xA5A5_0000+i.
